// File: rtl/split_add_pkg.sv
// Shared types for the split-adder scheduler.
// Holds the scheduler FSM state encoding.
package split_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        RESP = 2'd3
    } sched_state_t;

endpackage

// File: rtl/half_add_stage.sv
// One M-bit adder slice with carry in/out.
// Reused for both halves of the N-bit sum.
module half_add_stage #(
    parameter int M = 32
) (
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    input  logic         cin_i,
    output logic [M-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{M{1'b0}}, cin_i};

endmodule

// File: rtl/split_add_scheduler.sv
// Round-robin scheduler sharing one half-width adder among K requesters.
// Each sum takes a low pass then a high pass; results are fully registered.
module split_add_scheduler
    import split_add_pkg::*;
#(
    parameter  int N   = 64,
    parameter  int K   = 4,
    localparam int IDW = $clog2(K)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [K-1:0]   req_valid,
    output logic [K-1:0]   req_ready,
    input  logic [K*N-1:0] req_a,
    input  logic [K*N-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [N-1:0]   rsp_sum,
    output logic           rsp_cout,
    output logic           rsp_ovf,
    output logic           busy
);

    localparam int M = N / 2;

    sched_state_t   state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, id_q, rsp_id_q;
    logic [N-1:0]   a_q, b_q, rsp_sum_q;
    logic [M-1:0]   sum_lo_q;
    logic           c_lo_q;
    logic           rsp_valid_q, rsp_cout_q, rsp_ovf_q;

    logic [M-1:0]   add_a, add_b, add_sum;
    logic           add_cin, add_cout;
    logic           pick_vld, accept;
    logic [IDW-1:0] pick_idx;

    // Lowest offset from ptr wins, so iterate from the far end down.
    function automatic logic [IDW:0] rr_pick(
        input logic [K-1:0]   v,
        input logic [IDW-1:0] ptr
    );
        logic [IDW:0] r;
        int idx;
        r = '0;
        for (int i = K - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % K;
            if (v[idx]) r = {1'b1, IDW'(idx)};
        end
        return r;
    endfunction

    assign {pick_vld, pick_idx} = rr_pick(req_valid, rr_ptr_q);
    assign accept = (state_q == IDLE) && pick_vld;

    half_add_stage #(.M(M)) u_add (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_vld) state_d = LOW;
            LOW:     state_d = HIGH;
            HIGH:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (state_q != IDLE);
        add_a     = a_q[M-1:0];
        add_b     = b_q[M-1:0];
        add_cin   = 1'b0;
        if (state_q == IDLE && pick_vld && rst) req_ready[pick_idx] = 1'b1;
        if (state_q == HIGH) begin
            add_a   = a_q[N-1:M];
            add_b   = b_q[N-1:M];
            add_cin = c_lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_lo_q    <= '0;
            c_lo_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= req_a[int'(pick_idx) * N +: N];
                b_q      <= req_b[int'(pick_idx) * N +: N];
                id_q     <= pick_idx;
                rr_ptr_q <= (pick_idx == IDW'(K - 1)) ? '0 : pick_idx + 1'b1;
            end
            if (state_q == LOW) begin
                sum_lo_q <= add_sum;
                c_lo_q   <= add_cout;
            end
            if (state_q == HIGH) begin
                rsp_sum_q   <= {add_sum, sum_lo_q};
                rsp_cout_q  <= add_cout;
                rsp_ovf_q   <= (a_q[N-1] == b_q[N-1]) && (add_sum[M-1] != a_q[N-1]);
                rsp_id_q    <= id_q;
                rsp_valid_q <= 1'b1;
            end
            if (state_q == RESP && rsp_ready) rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_split_add_scheduler.sv
// Scenario bench for split_add_scheduler.
// Scoreboard models each granted request as a full-width add.
module tb_split_add_scheduler;

    localparam int N   = 64;
    localparam int K   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [K-1:0]   req_valid = '0;
    logic [K-1:0]   req_ready;
    logic [K*N-1:0] req_a = '0;
    logic [K*N-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic [N-1:0]   rsp_sum;
    logic           rsp_cout, rsp_ovf, busy;

    always #5 clk = ~clk;

    split_add_scheduler #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N-1:0]   sum;
        logic           cout;
        logic           ovf;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [N:0]  m_s;
    logic [N-1:0] m_a, m_b;
    exp_t        m_e;

    // Scoreboard: push on grant, pop on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
        end else begin
            if (req_ready != '0) begin
                tests++;
                if ($countones(req_ready) != 1) begin
                    fails++;
                    $display("FAIL ready_onehot got=%b want=one-hot", req_ready);
                end
                for (int i = 0; i < K; i++) begin
                    if (req_ready[i]) begin
                        m_a = req_a[i*N +: N];
                        m_b = req_b[i*N +: N];
                        m_s = {1'b0, m_a} + {1'b0, m_b};
                        m_e.id   = IDW'(i);
                        m_e.sum  = m_s[N-1:0];
                        m_e.cout = m_s[N];
                        m_e.ovf  = (m_a[N-1] == m_b[N-1]) && (m_s[N-1] != m_a[N-1]);
                        sb.push_back(m_e);
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected got id=%0d sum=%h want=no response", rsp_id, rsp_sum);
                end else begin
                    m_e = sb.pop_front();
                    if ({rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== m_e) begin
                        fails++;
                        $display("FAIL sb_rsp got id=%0d sum=%h c=%b v=%b want id=%0d sum=%h c=%b v=%b",
                                 rsp_id, rsp_sum, rsp_cout, rsp_ovf, m_e.id, m_e.sum, m_e.cout, m_e.ovf);
                    end
                end
            end
        end
    end

    task automatic run_one(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                           output bit ok, output int lat, output logic [IDW-1:0] id,
                           output logic [N-1:0] sum, output logic cout, output logic ovf);
        ok = 0; lat = 0; id = '0; sum = '0; cout = 0; ovf = 0;
        @(posedge clk); #1;
        req_a[idx*N +: N] = a;
        req_b[idx*N +: N] = b;
        req_valid[idx] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[idx]) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        req_a[idx*N +: N] = ~a;
        req_b[idx*N +: N] = ~b;
        if (!ok) return;
        ok = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1; lat = k; id = rsp_id; sum = rsp_sum; cout = rsp_cout; ovf = rsp_ovf;
                break;
            end
        end
    endtask

    task automatic drain(output bit done);
        done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !rsp_valid) begin done = 1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = '1;
        #1;
        tests++; if (req_ready !== '0) begin fails++; $display("FAIL rst_ready got=%b want=0", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b want=0", rsp_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b want=0", busy); end
        tests++;
        if ({rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== '0) begin
            fails++; $display("FAIL rst_rsp got id=%0d sum=%h c=%b v=%b want all 0", rsp_id, rsp_sum, rsp_cout, rsp_ovf);
        end
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_single();
        bit ok; int lat; logic [IDW-1:0] id; logic [N-1:0] s; logic c, v;
        rsp_ready = 1'b1;
        run_one(2, '1, 64'd1, ok, lat, id, s, c, v);
        tests++; if (!ok) begin fails++; $display("FAIL t1_done got=%0d want=1", ok); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL t1_latency got=%0d want=3", lat); end
        tests++; if (s !== 64'd0) begin fails++; $display("FAIL t1_sum got=%h want=0", s); end
        tests++; if (c !== 1'b1) begin fails++; $display("FAIL t1_cout got=%b want=1", c); end
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL t1_ovf got=%b want=0", v); end
        tests++; if (id !== 2'd2) begin fails++; $display("FAIL t1_id got=%0d want=2", id); end
    endtask

    task automatic test_carry();
        bit ok; int lat; logic [IDW-1:0] id; logic [N-1:0] s; logic c, v;
        run_one(3, 64'h0000_0000_FFFF_FFFF, 64'd1, ok, lat, id, s, c, v);
        tests++; if (!ok) begin fails++; $display("FAIL t2_done got=%0d want=1", ok); end
        tests++; if (s !== 64'h0000_0001_0000_0000) begin fails++; $display("FAIL t2_sum got=%h want=0000000100000000", s); end
        tests++; if (c !== 1'b0) begin fails++; $display("FAIL t2_cout got=%b want=0", c); end
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL t2_ovf got=%b want=0", v); end
    endtask

    task automatic test_overflow();
        bit ok; int lat; logic [IDW-1:0] id; logic [N-1:0] s; logic c, v;
        run_one(3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ok, lat, id, s, c, v);
        tests++; if (!ok) begin fails++; $display("FAIL t3_done got=%0d want=1", ok); end
        tests++; if (s !== 64'h8000_0000_0000_0000) begin fails++; $display("FAIL t3_sum got=%h want=8000000000000000", s); end
        tests++; if (v !== 1'b1) begin fails++; $display("FAIL t3_ovf got=%b want=1", v); end
        tests++; if (c !== 1'b0) begin fails++; $display("FAIL t3_cout got=%b want=0", c); end
        tests++; if (id !== 2'd3) begin fails++; $display("FAIL t3_id got=%0d want=3", id); end
    endtask

    task automatic test_back_to_back();
        int g[$]; int gc[$]; int rid[$]; bit done;
        @(posedge clk); #1;
        for (int i = 0; i < K; i++) begin
            req_a[i*N +: N] = {$urandom, $urandom};
            req_b[i*N +: N] = {$urandom, $urandom};
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && rid.size() < 5; cyc++) begin
            @(negedge clk);
            if (req_ready != '0 && g.size() < 5) begin
                for (int i = 0; i < K; i++) if (req_ready[i]) g.push_back(i);
                gc.push_back(cyc);
            end
            if (rsp_valid) rid.push_back(int'(rsp_id));
            if (g.size() == 5 && req_valid != '0) begin
                @(posedge clk); #1;
                req_valid = '0;
            end
        end
        tests++; if (g.size() != 5) begin fails++; $display("FAIL t4_grants got=%0d want=5", g.size()); end
        tests++; if (rid.size() != 5) begin fails++; $display("FAIL t4_rsps got=%0d want=5", rid.size()); end
        for (int i = 0; i < g.size(); i++) begin
            tests++; if (g[i] != i % K) begin fails++; $display("FAIL t4_grant%0d got=%0d want=%0d", i, g[i], i % K); end
        end
        for (int i = 0; i < rid.size(); i++) begin
            tests++; if (rid[i] != i % K) begin fails++; $display("FAIL t4_id%0d got=%0d want=%0d", i, rid[i], i % K); end
        end
        for (int i = 1; i < gc.size(); i++) begin
            tests++; if (gc[i] - gc[i-1] != 4) begin fails++; $display("FAIL t4_gap%0d got=%0d want=4", i, gc[i] - gc[i-1]); end
        end
        drain(done);
        tests++; if (!done) begin fails++; $display("FAIL t4_drain got=%0d want=1", done); end
    endtask

    task automatic test_backpressure();
        bit ok; int lat; logic [IDW-1:0] id; logic [N-1:0] s; logic c, v; bit done;
        logic [N-1:0] ea, eb, es;
        ea = 64'h1234_5678_9ABC_DEF0;
        eb = 64'h0FED_CBA9_8765_4321;
        es = ea + eb;
        rsp_ready = 1'b0;
        run_one(1, ea, eb, ok, lat, id, s, c, v);
        tests++; if (!ok) begin fails++; $display("FAIL t5_done got=%0d want=1", ok); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            req_a[2*N +: N] = 64'd5;
            req_b[2*N +: N] = 64'd7;
            req_valid[2] = 1'b1;
            @(negedge clk);
            tests++;
            if (rsp_valid !== 1'b1 || rsp_sum !== es || rsp_id !== 2'd1) begin
                fails++;
                $display("FAIL t5_hold%0d got v=%b sum=%h id=%0d want v=1 sum=%h id=1", k, rsp_valid, rsp_sum, rsp_id, es);
            end
            tests++; if (req_ready !== '0) begin fails++; $display("FAIL t5_ready%0d got=%b want=0", k, req_ready); end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL t5_next_accept got=%b want=0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        drain(done);
        tests++; if (!done) begin fails++; $display("FAIL t5_drain got=%0d want=1", done); end
    endtask

    task automatic test_reset_mid();
        bit ok; bit done;
        rsp_ready = 1'b1;
        ok = 0;
        @(posedge clk); #1;
        req_a[1*N +: N] = 64'hDEAD_BEEF_0000_0001;
        req_b[1*N +: N] = 64'h0000_0000_FFFF_FFFF;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[1]) begin ok = 1; break; end
        end
        tests++; if (!ok) begin fails++; $display("FAIL t6_grant got=%0d want=1", ok); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL t6_busy_high got=%b want=1", busy); end
        #1;
        rst = 1'b0;
        req_valid = '1;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t6_busy got=%b want=0", busy); end
        tests++; if (req_ready !== '0) begin fails++; $display("FAIL t6_ready got=%b want=0", req_ready); end
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== '0) begin
            fails++; $display("FAIL t6_rsp got v=%b id=%0d sum=%h want all 0", rsp_valid, rsp_id, rsp_sum);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL t6_ptr got=%b want=0001", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL t6_stale got=%b want=0", rsp_valid); end
        @(posedge clk); #1;
        req_valid = '0;
        drain(done);
        tests++; if (!done) begin fails++; $display("FAIL t6_drain got=%0d want=1", done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL sb_left got=%0d want=0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
